// File: rtl/button_conditioner.sv
// Push-button front end: per-channel 2-FF synchroniser, debounce counter,
// clean active-high level plus one-cycle press/release pulses.

module button_conditioner_lane #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_WIDTH       = 17,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic                 REL_PIN = (ACTIVE_LOW != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 press_q, press_d;
  logic                 rel_q, rel_d;
  logic                 s;

  // Synchroniser idles at the released pin level so reset looks like "not pressed".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= REL_PIN;
      sync2_q <= REL_PIN;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q ^ REL_PIN;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = s;
      cnt_d   = '0;
      press_d = s;
      rel_d   = ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

module button_conditioner #(
  parameter int N_BUTTONS       = 5,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_WIDTH       = 17,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release
);

  // The counter must hold DEBOUNCE_CYCLES-1 without wrapping.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if ((64'd1 << CNT_WIDTH) <= 64'(DEBOUNCE_CYCLES - 1)) begin : g_bad_width
    $error("CNT_WIDTH too small for DEBOUNCE_CYCLES");
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_lane
    button_conditioner_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .btn_raw_i (btn_raw[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: expected level/pulse events are queued with their due edge
// when stimulus is applied, and every cycle's outputs are checked against them.

module tb_button_conditioner;

  localparam int NB  = 5;
  localparam int DC  = 4;
  localparam int LAT = DC + 1;  // sync1 capture edge -> output edge

  logic          clk;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level, btn_press, btn_release;

  button_conditioner #(
    .N_BUTTONS      (NB),
    .DEBOUNCE_CYCLES(DC),
    .CNT_WIDTH      (17),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int at;
    int ch;
    bit pr;
  } ev_t;

  ev_t           sb[$];
  int            edge_n = 0;
  int            n_cmp  = 0;
  int            n_bad  = 0;
  logic [NB-1:0] exp_level = '0;
  logic [NB-1:0] exp_press, exp_rel;

  task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s @edge %0d: got %b want %b", tag, edge_n, got, exp);
    end
  endtask

  task automatic push(input int at, input int ch, input bit pr);
    ev_t e;
    e.at = at;
    e.ch = ch;
    e.pr = pr;
    sb.push_back(e);
  endtask

  // One clock: advance edge count, then check on the falling edge.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    exp_press = '0;
    exp_rel   = '0;
    if (!reset) exp_level = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == edge_n) begin
        exp_level[sb[i].ch] = sb[i].pr;
        if (sb[i].pr) exp_press[sb[i].ch] = 1'b1;
        else          exp_rel[sb[i].ch]   = 1'b1;
        sb.delete(i);
      end
    end
    chk("level",   btn_level,   exp_level);
    chk("press",   btn_press,   exp_press);
    chk("release", btn_release, exp_rel);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = '0;
    #2 reset = 1'b0;

    // Reset held with all buttons pressed: outputs stay 0.
    ticks(3);
    reset = 1'b1;
    for (int c = 0; c < NB; c++) push(edge_n + 1 + LAT, c, 1'b1);
    ticks(8);

    // Release everything.
    btn_raw = '1;
    for (int c = 0; c < NB; c++) push(edge_n + 1 + LAT, c, 1'b0);
    ticks(8);

    // Clean press on enter.
    btn_raw[4] = 1'b0;
    push(edge_n + 1 + LAT, 4, 1'b1);
    ticks(8);

    // Bounce on channel 0: 3-cycle holds never reach the outputs.
    for (int j = 0; j < 4; j++) begin
      btn_raw[0] = j[0];
      ticks(3);
    end
    btn_raw[0] = 1'b0;
    push(edge_n + 1 + LAT, 0, 1'b1);
    ticks(8);

    // Press then release on channel 2.
    btn_raw[2] = 1'b0;
    push(edge_n + 1 + LAT, 2, 1'b1);
    ticks(7);
    btn_raw[2] = 1'b1;
    push(edge_n + 1 + LAT, 2, 1'b0);
    ticks(7);

    // Channels 1 and 3 together; channel 3 glitches at count 2.
    btn_raw[1] = 1'b0;
    btn_raw[3] = 1'b0;
    push(edge_n + 1 + LAT, 1, 1'b1);
    ticks(2);
    btn_raw[3] = 1'b1;
    ticks(2);
    btn_raw[3] = 1'b0;
    push(edge_n + 1 + LAT, 3, 1'b1);
    ticks(8);

    // Release channel 0 so it can be re-pressed across a reset.
    btn_raw[0] = 1'b1;
    push(edge_n + 1 + LAT, 0, 1'b0);
    ticks(7);

    // Press channel 0, assert reset with its count at 2.
    btn_raw[0] = 1'b0;
    ticks(4);
    reset = 1'b0;
    #1;
    chk("rst_level",   btn_level,   '0);
    chk("rst_press",   btn_press,   '0);
    chk("rst_release", btn_release, '0);
    ticks(2);
    reset = 1'b1;
    push(edge_n + 1 + LAT, 0, 1'b1);
    push(edge_n + 1 + LAT, 1, 1'b1);
    push(edge_n + 1 + LAT, 3, 1'b1);
    push(edge_n + 1 + LAT, 4, 1'b1);
    ticks(10);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL pending_events: got %0d want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
